dbnc_multi: RTL

- Parametrised N-channel push-button debouncer with optional long-press detection.
- Sits between the raw board button/switch pins and the lab control FSMs.
- Uses the shared 1 ms tick (`m_sec`) from the clock divider as its time base.
- Per channel it provides a synchronised, debounced level, one-cycle press/release pulses and a long-press ("hold") flag.

---
 rtl/dbnc_multi_if.sv | 23 ++
 rtl/dbnc_multi.sv | 119 +++++++++++
 2 files changed

// File: rtl/dbnc_multi_if.sv
// dbnc_multi_if: button debouncer bus.
// Raw inputs and tick in, debounced level and events out.
interface dbnc_multi_if #(
    parameter int N_CH = 4
);
    logic            m_sec;
    logic [N_CH-1:0] btn_raw;
    logic [N_CH-1:0] btn_db;
    logic [N_CH-1:0] press_p;
    logic [N_CH-1:0] rel_p;
    logic [N_CH-1:0] hold;
    logic [N_CH-1:0] busy;

    modport master (
        output m_sec, btn_raw,
        input  btn_db, press_p, rel_p, hold, busy
    );

    modport slave (
        input  m_sec, btn_raw,
        output btn_db, press_p, rel_p, hold, busy
    );
endinterface

// File: rtl/dbnc_multi.sv
// dbnc_multi: N-channel push-button debouncer
// with 1 ms time base and long-press detection.
module dbnc_multi #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 10,
    parameter int DBNC_MS = 500,
    parameter int HOLD_MS = 1000,
    parameter int HOLD_W  = 11
) (
    input  logic        clk,
    input  logic        rst,
    dbnc_multi_if.slave bus
);
    typedef enum logic {
        STABLE = 1'b0,
        DBNC   = 1'b1
    } state_t;

    if (DBNC_MS == 0 || DBNC_MS >= (1 << CNT_W)) begin : g_bad_dbnc
        $error("dbnc_multi: DBNC_MS out of range for CNT_W");
    end
    if (HOLD_MS >= (1 << HOLD_W)) begin : g_bad_hold
        $error("dbnc_multi: HOLD_MS out of range for HOLD_W");
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [1:0]       sync_q;
        logic             s;
        state_t           st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             db_q, db_d;
        logic             pr_q, pr_d;
        logic             rl_q, rl_d;
        logic             commit;
        logic             hold_w;

        assign s = sync_q[1];

        // Two-stage synchroniser for the asynchronous pin
        always_ff @(posedge clk) begin
            if (rst) sync_q <= '0;
            else     sync_q <= {sync_q[0], bus.btn_raw[ch]};
        end

        // State, countdown and registered level/pulses
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q  <= STABLE;
                cnt_q <= '0;
                db_q  <= 1'b0;
                pr_q  <= 1'b0;
                rl_q  <= 1'b0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                db_q  <= db_d;
                pr_q  <= pr_d;
                rl_q  <= rl_d;
            end
        end

        // Next state: bounce-back beats a tick, commit at cnt==0
        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            db_d   = db_q;
            pr_d   = 1'b0;
            rl_d   = 1'b0;
            commit = 1'b0;
            unique case (st_q)
                STABLE: begin
                    if (s != db_q) begin
                        st_d  = DBNC;
                        cnt_d = CNT_W'(DBNC_MS - 1);
                    end
                end
                DBNC: begin
                    if (s == db_q) begin
                        st_d = STABLE;
                    end else if (bus.m_sec && cnt_q == '0) begin
                        commit = 1'b1;
                        st_d   = STABLE;
                        db_d   = ~db_q;
                        pr_d   = ~db_q;
                        rl_d   = db_q;
                    end else if (bus.m_sec) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            endcase
        end

        if (HOLD_MS == 0) begin : g_nohold
            assign hold_w = 1'b0;
        end else begin : g_hold
            logic [HOLD_W-1:0] hcnt_q;
            logic              hold_q;

            // Long-press timer; freezes once hold is flagged
            always_ff @(posedge clk) begin
                if (rst || commit || !db_q) begin
                    hcnt_q <= '0;
                    hold_q <= 1'b0;
                end else if (!hold_q && bus.m_sec) begin
                    if (hcnt_q == HOLD_W'(HOLD_MS - 1)) hold_q <= 1'b1;
                    else hcnt_q <= hcnt_q + 1'b1;
                end
            end

            assign hold_w = hold_q;
        end

        assign bus.btn_db[ch]  = db_q;
        assign bus.press_p[ch] = pr_q;
        assign bus.rel_p[ch]   = rl_q;
        assign bus.hold[ch]    = hold_w;
        assign bus.busy[ch]    = (st_q == DBNC);
    end
endmodule
